// File: rtl/serial_pattern_source_if.sv
// Parallel-in handshake and serial-out bundle for serial_pattern_source.
// The master side feeds words and watches the stream; the slave side is the serialiser.
interface serial_pattern_source_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, ser_out, ser_valid, frame_start, busy
    );
endinterface

// File: rtl/serial_pattern_source.sv
// Word-to-bit serialiser feeding the sequence pattern detector: a one-word holding
// register in front of a shifter, so consecutive words stream without an idle bit.
module serial_pattern_source #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  restn,
    serial_pattern_source_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_p0;
    logic             hold_full;
    logic [WIDTH-1:0] shift_p1;
    logic [CW-1:0]    cnt_p1;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             frame_start_q;
    logic             accept;
    logic             load_en;
    logic             shift_en;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Load happens either from idle or straight after the last bit, never alongside an accept.
    assign accept   = bus.data_valid && !hold_full;
    assign load_en  = hold_full && ((state == IDLE) || (cnt_p1 == LAST));
    assign shift_en = (state == SHIFT) && (cnt_p1 != LAST);

    // Stage p0 -> p1: word storage; qualified by hold_full / state, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) hold_p0 <= bus.data_in;
        if (load_en) begin
            shift_p1 <= advance(hold_p0);
        end else if (shift_en) begin
            shift_p1 <= advance(shift_p1);
        end
    end

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state         <= IDLE;
            hold_full     <= 1'b0;
            cnt_p1        <= '0;
            ser_out_q     <= IDLE_BIT;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (load_en) begin
                state         <= SHIFT;
                cnt_p1        <= '0;
                ser_out_q     <= first_bit(hold_p0);
                ser_valid_q   <= 1'b1;
                frame_start_q <= 1'b1;
            end else if (shift_en) begin
                cnt_p1        <= cnt_p1 + 1'b1;
                ser_out_q     <= first_bit(shift_p1);
                frame_start_q <= 1'b0;
            end else if (state == SHIFT) begin
                state         <= IDLE;
                cnt_p1        <= '0;
                ser_out_q     <= IDLE_BIT;
                ser_valid_q   <= 1'b0;
                frame_start_q <= 1'b0;
            end

            if (accept) begin
                hold_full <= 1'b1;
            end else if (load_en) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign bus.data_ready  = !hold_full;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = ser_valid_q || hold_full;
endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: MSB-first instance against a bit-queue reference
// model, plus an LSB-first instance checked against explicit bit orders.
module tb_serial_pattern_source;
    localparam int W    = 8;
    localparam bit IDLE = 1'b0;

    logic clk = 1'b0;
    logic restn;
    always #5 clk = ~clk;

    serial_pattern_source_if #(.WIDTH(W)) ifm ();
    serial_pattern_source_if #(.WIDTH(W)) ifl ();

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_msb (
        .clk(clk), .restn(restn), .bus(ifm)
    );
    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_lsb (
        .clk(clk), .restn(restn), .bus(ifl)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: one pending word slot and a queue of bits still to appear on the wire.
    typedef struct packed { logic b; logic f; } sbit_t;
    sbit_t        m_q[$];
    logic [W-1:0] m_hold;
    bit           m_hold_v = 1'b0;
    bit           m_acc    = 1'b0;

    always @(posedge clk or negedge restn) begin
        if (!restn) begin
            m_q.delete();
            m_hold_v = 1'b0;
            m_acc    = 1'b0;
        end else begin
            m_acc = ifm.data_valid && !m_hold_v;
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_q.size() == 0 && m_hold_v) begin
                for (int i = 0; i < W; i++) m_q.push_back(sbit_t'{m_hold[W-1-i], (i == 0)});
                m_hold_v = 1'b0;
            end
            if (m_acc) begin
                m_hold   = ifm.data_in;
                m_hold_v = 1'b1;
            end
        end
    end

    function automatic logic [4:0] exp_vec();
        if (m_q.size() > 0) return {m_q[0].b, 1'b1, m_q[0].f, !m_hold_v, 1'b1};
        return {IDLE, 1'b0, 1'b0, !m_hold_v, m_hold_v};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {ifm.ser_out, ifm.ser_valid, ifm.frame_start, ifm.data_ready, ifm.busy};
    endfunction

    // Upstream driver: holds a word until the model says it was taken, optional random gaps.
    logic [W-1:0] tx_q[$];
    bit           gap_mode = 1'b0;

    task automatic drive_next();
        bit presenting;
        presenting = ifm.data_valid && !m_acc;
        if (ifm.data_valid && m_acc && tx_q.size() > 0) void'(tx_q.pop_front());
        if (tx_q.size() > 0 && (presenting || !gap_mode || $urandom_range(0, 2) != 0)) begin
            ifm.data_valid = 1'b1;
            ifm.data_in    = tx_q[0];
        end else begin
            ifm.data_valid = 1'b0;
            ifm.data_in    = W'($urandom);
        end
    endtask

    task automatic test_reset();
        restn = 1'b0;
        ifm.data_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== {IDLE, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", c, obs_vec(), {IDLE, 4'b0010});
            end
        end
        restn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] bits = '0;
        int nb = 0, nfs = 0;
        gap_mode = 1'b0;
        tx_q.push_back(8'hD7);
        drive_next();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
            if (ifm.ser_valid) begin bits = {bits[W-2:0], ifm.ser_out}; nb++; end
            if (ifm.frame_start) nfs++;
            drive_next();
        end
        vectors++;
        if (bits !== 8'hD7 || nb != 8 || nfs != 1) begin
            miscompares++;
            $display("FAIL single_bits got=%h/%0d/%0d want=d7/8/1", bits, nb, nfs);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits = '0;
        int nb = 0, nfs = 0, first = -1, last = -1;
        gap_mode = 1'b0;
        tx_q.push_back(8'hB5);
        tx_q.push_back(8'h2D);
        drive_next();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
            if (ifm.ser_valid) begin
                bits = {bits[14:0], ifm.ser_out};
                nb++;
                if (first < 0) first = c;
                last = c;
            end
            if (ifm.frame_start) nfs++;
            drive_next();
        end
        vectors++;
        if (bits !== 16'hB52D || nb != 16 || nfs != 2 || (last - first) != 15) begin
            miscompares++;
            $display("FAIL b2b_stream got=%h n=%0d fs=%0d span=%0d want=b52d n=16 fs=2 span=15",
                     bits, nb, nfs, last - first);
        end
    endtask

    task automatic run_words(input string name, input int n, input bit gaps, input int budget);
        logic [W-1:0] sent[$];
        logic         bq[$];
        logic [W-1:0] w;
        bit           done = 1'b0;
        gap_mode = gaps;
        for (int k = 0; k < n; k++) begin
            w = W'($urandom);
            sent.push_back(w);
            tx_q.push_back(w);
        end
        drive_next();
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, c, obs_vec(), exp_vec());
            end
            if (ifm.ser_valid) bq.push_back(ifm.ser_out);
            drive_next();
            if (tx_q.size() == 0 && !ifm.data_valid && m_q.size() == 0 && !m_hold_v) done = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (!done || bq.size() != n * W) begin
            miscompares++;
            $display("FAIL %s_count got=%0d bits done=%0d want=%0d bits", name, bq.size(), done, n * W);
        end else begin
            for (int k = 0; k < n; k++) begin
                w = '0;
                for (int i = 0; i < W; i++) w = {w[W-2:0], bq[k*W+i]};
                vectors++;
                if (w !== sent[k]) begin
                    miscompares++;
                    $display("FAIL %s_word%0d got=%h want=%h", name, k, w, sent[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        run_words("backpressure", 3, 1'b0, 60);
    endtask

    task automatic test_random_stream();
        run_words("random_stream", 12, 1'b1, 400);
    endtask

    task automatic lsb_word(input logic [W-1:0] w, input logic [W-1:0] want);
        logic [W-1:0] bits = '0;
        int nb = 0, nfs = 0;
        bit fs_ok = 1'b1;
        @(negedge clk);
        ifl.data_in    = w;
        ifl.data_valid = 1'b1;
        @(negedge clk);
        ifl.data_valid = 1'b0;
        ifl.data_in    = W'($urandom);
        for (int c = 0; c < 11; c++) begin
            if (ifl.ser_valid) begin
                if (ifl.frame_start != (nb == 0)) fs_ok = 1'b0;
                bits = {bits[W-2:0], ifl.ser_out};
                nb++;
            end
            if (ifl.frame_start) nfs++;
            @(negedge clk);
        end
        vectors++;
        if (bits !== want || nb != W || nfs != 1 || !fs_ok) begin
            miscompares++;
            $display("FAIL lsb_order in=%h got=%b n=%0d fs=%0d want=%b", w, bits, nb, nfs, want);
        end
        vectors++;
        if ({ifl.ser_out, ifl.ser_valid, ifl.data_ready, ifl.busy} !== {IDLE, 3'b010}) begin
            miscompares++;
            $display("FAIL lsb_idle got=%b want=%b", {ifl.ser_out, ifl.ser_valid, ifl.data_ready, ifl.busy},
                     {IDLE, 3'b010});
        end
    endtask

    task automatic test_lsb();
        logic [W-1:0] w, want;
        lsb_word(8'b1110_1101, 8'b1011_0111);
        w = W'($urandom);
        for (int i = 0; i < W; i++) want[W-1-i] = w[i];
        lsb_word(w, want);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] bits = '0;
        int nb = 0;
        bit first_fs = 1'b0;
        gap_mode = 1'b0;
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        drive_next();
        for (int c = 0; c < 20 && nb < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midreset_pre cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
            if (ifm.ser_valid) nb++;
            if (nb < 3) drive_next();
        end
        vectors++;
        if (nb != 3 || ifm.busy !== 1'b1 || ifm.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_setup bits=%0d busy=%b ready=%b want 3/1/0", nb, ifm.busy, ifm.data_ready);
        end
        #2 restn = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== {IDLE, 4'b0010}) begin
            miscompares++;
            $display("FAIL midreset_async got=%b want=%b", obs_vec(), {IDLE, 4'b0010});
        end
        tx_q.delete();
        ifm.data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        restn = 1'b1;
        tx_q.push_back(8'h0F);
        drive_next();
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midreset_post cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
            if (ifm.ser_valid) begin
                if (nb == 0) first_fs = ifm.frame_start;
                bits = {bits[W-2:0], ifm.ser_out};
                nb++;
            end
            drive_next();
        end
        vectors++;
        if (bits !== 8'h0F || nb != 8 || !first_fs) begin
            miscompares++;
            $display("FAIL midreset_word got=%h n=%0d fs=%0d want=0f n=8 fs=1", bits, nb, first_fs);
        end
    endtask

    initial begin
        restn          = 1'b0;
        ifm.data_valid = 1'b0;
        ifm.data_in    = '0;
        ifl.data_valid = 1'b0;
        ifl.data_in    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_lsb();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
